// File: rtl/count_req_master_pkg.sv
// Shared definitions for the count-request initiator: FSM state encoding and default widths.
package count_req_master_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_ACK      = 2'd3;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/count_req_master_req_serialiser.sv
// Loads a parallel word and shifts it out MSB-first, with a strobe that stays high for DATA_W cycles.
module count_req_master_req_serialiser
    import count_req_master_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_req,
    output logic              o_req_data,
    output logic              o_last
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_shreg;
    logic [BC_W-1:0]   r_bitcnt;
    logic              r_req;

    // The shift register MSB is the serial bit; it drains to zero by the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_req    <= 1'b0;
        end else if (i_load) begin
            r_shreg  <= i_data;
            r_bitcnt <= BC_W'(DATA_W - 1);
            r_req    <= 1'b1;
        end else if (r_req) begin
            r_shreg <= r_shreg << 1;
            if (r_bitcnt == '0) begin
                r_req <= 1'b0;
            end else begin
                r_bitcnt <= r_bitcnt - BC_W'(1);
            end
        end
    end

    assign o_req      = r_req;
    assign o_req_data = r_shreg[DATA_W-1];
    assign o_last     = r_req && (r_bitcnt == '0);

endmodule

// File: rtl/count_req_master.sv
// Initiator of the serial count-request protocol: sends a delay frame, waits for the
// responder's result, acknowledges it and reports elapsed cycles or a timeout.
module count_req_master
    import count_req_master_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              cmd_ready_o,
    output logic              req_o,
    output logic              req_data_o,
    input  logic              busy_i,
    input  logic              rsp_i,
    output logic              ack_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  elapsed_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_ack;
    logic             r_done;
    logic             r_timeout;

    logic w_accept;
    logic w_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_ready_o = (r_state == ST_IDLE) && !busy_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    count_req_master_req_serialiser #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_data     (cmd_data_i),
        .o_req      (req_o),
        .o_req_data (req_data_o),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_elapsed <= '0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_cnt <= sat_inc(r_cnt);
                    if (w_last) r_state <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    r_cnt <= sat_inc(r_cnt);
                    // A response arriving on the timeout cycle still takes the ACK path.
                    if (rsp_i) begin
                        r_elapsed <= r_cnt;
                        r_state   <= ST_ACK;
                    end else if (r_cnt >= TIMEOUT_C) begin
                        r_elapsed <= TIMEOUT_C;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    if (rsp_i) begin
                        r_ack <= 1'b1;
                    end else begin
                        r_ack   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign ack_o     = r_ack;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
    assign elapsed_o = r_elapsed;

endmodule

// File: tb/tb_count_req_master.sv
// Directed bench for count_req_master: table of whole transactions plus busy and reset sequences.
module tb_count_req_master;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;

    logic              clk;
    logic              rst;
    logic              cmd_valid_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              cmd_ready_o;
    logic              req_o;
    logic              req_data_o;
    logic              busy_i;
    logic              rsp_i;
    logic              ack_o;
    logic              done_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  elapsed_o;

    int n_checks = 0;
    int n_errors = 0;

    count_req_master #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_data_i (cmd_data_i),
        .cmd_ready_o(cmd_ready_o),
        .req_o      (req_o),
        .req_data_o (req_data_o),
        .busy_i     (busy_i),
        .rsp_i      (rsp_i),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .elapsed_o  (elapsed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         spur;     // cycle of a one-cycle rsp_i pulse during the frame, -1 none
        int         rsp_at;   // cycle (0 = first req cycle) responder raises rsp_i, -1 never
        int         exp_el;
        logic       exp_to;
    } txn_t;

    txn_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [7:0] d);
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        #1;
        check("cmd_ready_idle", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // Entered on the first req cycle; plays the responder until done_o, then checks the pulse ends.
    task automatic observe(input logic [7:0] data, input int spur, input int rsp_at,
                           input int exp_el, input logic exp_to);
        int first_ack = -1;
        int acks      = 0;
        int done_c    = -1;
        int exp_done  = (rsp_at >= 0) ? rsp_at + 5 : TIMEOUT + 1;
        for (int c = 0; c < 150 && done_c < 0; c++) begin
            if (c < DATA_W) begin
                check("req_high", req_o, 1);
                check("req_bit", req_data_o, data[DATA_W-1-c]);
                check("ready_low_frame", cmd_ready_o, 0);
            end else if (c == DATA_W) begin
                check("req_low_after_frame", req_o, 0);
            end
            if (ack_o) begin
                acks++;
                if (first_ack < 0) first_ack = c;
            end
            if (done_o) begin
                done_c = c;
                check("done_cycle", c, exp_done);
                check("timeout_flag", timeout_o, exp_to);
                check("elapsed", elapsed_o, exp_el);
                check("ack_cycles", acks, (rsp_at >= 0) ? 3 : 0);
                check("ready_on_done", cmd_ready_o, 1);
            end else begin
                rsp_i = (c == spur) ||
                        (rsp_at >= 0 && c >= rsp_at && (first_ack < 0 || c < first_ack + 2));
                tick();
            end
        end
        if (done_c < 0) check("done_seen", 0, 1);
        rsp_i = 1'b0;
        tick();
        check("done_single", done_o, 0);
        check("timeout_single", timeout_o, 0);
        check("elapsed_held", elapsed_o, exp_el);
    endtask

    initial begin
        tbl[0] = '{data: 8'hA5, spur: -1, rsp_at: 20, exp_el: 20, exp_to: 1'b0};
        tbl[1] = '{data: 8'h3C, spur: -1, rsp_at: 8,  exp_el: 8,  exp_to: 1'b0};
        tbl[2] = '{data: 8'hFF, spur: -1, rsp_at: -1, exp_el: 50, exp_to: 1'b1};
        tbl[3] = '{data: 8'h00, spur: -1, rsp_at: 50, exp_el: 50, exp_to: 1'b0};
        tbl[4] = '{data: 8'h96, spur: 3,  rsp_at: 25, exp_el: 25, exp_to: 1'b0};
        tbl[5] = '{data: 8'hE7, spur: 5,  rsp_at: -1, exp_el: 50, exp_to: 1'b1};

        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
        busy_i      = 1'b0;
        rsp_i       = 1'b0;
        tick();
        tick();
        check("rst_req", req_o, 0);
        check("rst_req_data", req_data_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_done", done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_elapsed", elapsed_o, 0);
        check("rst_ready", cmd_ready_o, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            accept(tbl[i].data);
            observe(tbl[i].data, tbl[i].spur, tbl[i].rsp_at, tbl[i].exp_el, tbl[i].exp_to);
        end

        // Busy responder blocks acceptance; command is taken the cycle busy_i drops.
        busy_i      = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy_ready_low", cmd_ready_o, 0);
            check("busy_no_req", req_o, 0);
            tick();
        end
        busy_i = 1'b0;
        #1;
        check("busy_release_ready", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        observe(8'h55, -1, 12, 12, 1'b0);

        // Reset on the 4th SEND cycle aborts the frame at once.
        accept(8'hC3);
        tick();
        tick();
        tick();
        check("pre_rst_req", req_o, 1);
        rst = 1'b1;
        #1;
        check("midrst_req", req_o, 0);
        check("midrst_req_data", req_data_o, 0);
        check("midrst_elapsed", elapsed_o, 0);
        check("midrst_ready", cmd_ready_o, 1);
        tick();
        check("midrst_hold_req", req_o, 0);
        rst = 1'b0;
        tick();
        check("postrst_req", req_o, 0);
        accept(8'h03);
        observe(8'h03, -1, 15, 15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
